pc_gen_unit: RTL and testbench



---
 rtl/rv_pkg.sv | 8 +
 rtl/pcg_ras.sv | 44 ++++
 rtl/pc_gen_unit.sv | 112 +++++++++++
 tb/tb_pc_gen_unit.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared definitions for the fetch-stage PC generator: FSM states and default vectors.
package rv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEF_TRAP_VECTOR  = 32'h0000_0100;

  typedef enum logic [1:0] {BOOT, RUN, HALTED} pcg_state_t;
endpackage

// File: rtl/pcg_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pcg_ras #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  logic                           swap,
  input  logic [WIDTH-1:0]               din,
  output logic [WIDTH-1:0]               top,
  output logic [$clog2(RAS_DEPTH):0]     count
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [RAS_DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0] ptr, top_idx;
  logic          full, empty;

  // ptr is the next write slot, so the top sits one below it
  assign top_idx = ptr - PW'(1);
  assign top     = mem[top_idx];
  assign full    = (count == CW'(RAS_DEPTH));
  assign empty   = (count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem   <= '0;
      ptr   <= '0;
      count <= '0;
    end else if (swap) begin
      mem[top_idx] <= din;
    end else if (push) begin
      mem[ptr] <= din;
      ptr      <= ptr + PW'(1);
      if (!full) count <= count + CW'(1);
    end else if (pop && !empty) begin
      ptr   <= top_idx;
      count <= count - CW'(1);
    end
  end
endmodule

// File: rtl/pc_gen_unit.sv
// Fetch-stage PC generator: handshake, stall, redirect, trap/EPC, halt/resume and RAS.
module pc_gen_unit
  import rv_pkg::*;
#(
  parameter int               WIDTH        = XLEN,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(DEF_TRAP_VECTOR),
  parameter int               INC          = 4,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_ready,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             trap,
  input  logic             call_push,
  input  logic             ret_pop,
  input  logic             halt_req,
  input  logic             resume,
  output logic [WIDTH-1:0] pc,
  output logic             pc_valid,
  output logic [WIDTH-1:0] epc,
  output logic             halted,
  output logic             ras_underflow
);
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(INC - 1);

  pcg_state_t state, state_nx;
  logic [WIDTH-1:0] pc_nx, epc_nx, pc_inc, redir_al, ras_top;
  logic [$clog2(RAS_DEPTH):0] ras_count;
  logic fire, ras_empty, ras_push, ras_pop, ras_swap, uflow_nx;

  assign fire      = pc_valid & fetch_ready & ~stall;
  assign pc_inc    = pc + WIDTH'(INC);
  assign redir_al  = redirect_pc & ALIGN_MASK;
  assign ras_empty = (ras_count == '0);

  pcg_ras #(.WIDTH(WIDTH), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (ras_push),
    .pop   (ras_pop),
    .swap  (ras_swap),
    .din   (pc_inc),
    .top   (ras_top),
    .count (ras_count)
  );

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    epc_nx   = epc;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    ras_swap = 1'b0;
    uflow_nx = 1'b0;
    case (state)
      BOOT: state_nx = RUN;
      RUN: begin
        if (halt_req) state_nx = HALTED;
        if (trap) begin
          pc_nx  = TRAP_VECTOR;
          epc_nx = pc;
        end else if (redirect_valid) begin
          pc_nx = redir_al;
        end else if (fire) begin
          if (ret_pop && !ras_empty) begin
            // call+return on a live stack replaces the top instead of pop+push
            pc_nx    = ras_top;
            ras_swap = call_push;
            ras_pop  = ~call_push;
          end else begin
            pc_nx    = pc_inc;
            ras_push = call_push;
            uflow_nx = ret_pop;
          end
        end
      end
      HALTED: begin
        if (trap) begin
          pc_nx    = TRAP_VECTOR;
          epc_nx   = pc;
          state_nx = RUN;
        end else begin
          if (redirect_valid) pc_nx = redir_al;
          if (resume && !halt_req) state_nx = RUN;
        end
      end
      default: state_nx = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= BOOT;
      pc            <= RESET_VECTOR;
      epc           <= '0;
      pc_valid      <= 1'b0;
      halted        <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      state         <= state_nx;
      pc            <= pc_nx;
      epc           <= epc_nx;
      pc_valid      <= (state_nx == RUN);
      halted        <= (state_nx == HALTED);
      ras_underflow <= uflow_nx;
    end
  end
endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed bench for pc_gen_unit with hand-computed expected values.
module tb_pc_gen_unit;
  logic        clk = 1'b0;
  logic        rst, fetch_ready, stall, redirect_valid, trap, call_push, ret_pop, halt_req, resume;
  logic [31:0] redirect_pc, pc, epc;
  logic        pc_valid, halted, ras_underflow;
  int          n_cmp = 0, n_err = 0;

  pc_gen_unit dut (
    .clk(clk), .rst(rst), .fetch_ready(fetch_ready), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .trap(trap),
    .call_push(call_push), .ret_pop(ret_pop), .halt_req(halt_req), .resume(resume),
    .pc(pc), .pc_valid(pc_valid), .epc(epc), .halted(halted), .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redir(input logic [31:0] a);
    redirect_valid = 1'b1;
    redirect_pc    = a;
    step();
    redirect_valid = 1'b0;
    chk("redir_pc", pc, a);
  endtask

  initial begin
    rst = 1'b1; fetch_ready = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    trap = 1'b0; call_push = 1'b0; ret_pop = 1'b0; halt_req = 1'b0; resume = 1'b0;
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", {31'b0, pc_valid}, 32'h0);
    chk("rst_epc", epc, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h0);
    chk("rst_uflow", {31'b0, ras_underflow}, 32'h0);
    step(); step();
    rst = 1'b0;
    #2;
    chk("boot_valid", {31'b0, pc_valid}, 32'h0);
    step();
    chk("run_valid", {31'b0, pc_valid}, 32'h1);
    chk("run_pc0", pc, 32'h0);
    step(); chk("seq_pc4", pc, 32'h4);
    step(); chk("seq_pc8", pc, 32'h8);

    // stall holds, redirect overrides stall and is aligned
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); chk("stall_hold", pc, 32'h8);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    step(); chk("stall_redir", pc, 32'h200);
    redirect_valid = 1'b0; stall = 1'b0;

    // wrap-around
    redir(32'hFFFF_FFFC);
    step(); chk("wrap", pc, 32'h0);

    // RAS fill past depth
    for (int i = 1; i <= 5; i++) begin
      redir(32'(i * 16));
      call_push = 1'b1;
      step();
      call_push = 1'b0;
      chk("push_seq", pc, 32'(i * 16 + 4));
    end
    ret_pop = 1'b1;
    step(); chk("pop1", pc, 32'h54); chk("pop1_uf", {31'b0, ras_underflow}, 32'h0);
    step(); chk("pop2", pc, 32'h44);
    step(); chk("pop3", pc, 32'h34);
    step(); chk("pop4", pc, 32'h24);
    step(); chk("pop5_seq", pc, 32'h28); chk("pop5_uf", {31'b0, ras_underflow}, 32'h1);
    ret_pop = 1'b0;
    step(); chk("uf_pulse_end", {31'b0, ras_underflow}, 32'h0); chk("after_uf", pc, 32'h2c);

    // trap beats redirect and squashes the push
    redir(32'h40);
    trap = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80; call_push = 1'b1;
    step();
    trap = 1'b0; redirect_valid = 1'b0; call_push = 1'b0;
    chk("trap_pc", pc, 32'h100);
    chk("trap_epc", epc, 32'h40);
    ret_pop = 1'b1;
    step(); chk("trap_nopush_pc", pc, 32'h104); chk("trap_nopush_uf", {31'b0, ras_underflow}, 32'h1);
    ret_pop = 1'b0;

    // halt with same-cycle fire, hold, halt+resume, resume
    redir(32'h20);
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    chk("halt_flag", {31'b0, halted}, 32'h1);
    chk("halt_valid", {31'b0, pc_valid}, 32'h0);
    chk("halt_pc", pc, 32'h24);
    step(); chk("halt_hold", pc, 32'h24);
    halt_req = 1'b1; resume = 1'b1;
    step(); chk("halt_both", {31'b0, halted}, 32'h1);
    halt_req = 1'b0;
    step(); resume = 1'b0;
    chk("resume_flag", {31'b0, halted}, 32'h0);
    chk("resume_valid", {31'b0, pc_valid}, 32'h1);
    chk("resume_pc", pc, 32'h24);
    step(); chk("resume_seq", pc, 32'h28);

    // redirect and trap while halted
    halt_req = 1'b1;
    step(); halt_req = 1'b0;
    chk("rehalt_pc", pc, 32'h2c);
    redirect_valid = 1'b1; redirect_pc = 32'h302;
    step(); redirect_valid = 1'b0;
    chk("halt_redir_pc", pc, 32'h300);
    chk("halt_redir_flag", {31'b0, halted}, 32'h1);
    trap = 1'b1;
    step(); trap = 1'b0;
    chk("halt_trap_pc", pc, 32'h100);
    chk("halt_trap_epc", epc, 32'h300);
    chk("halt_trap_run", {31'b0, pc_valid}, 32'h1);

    // async reset in HALTED
    halt_req = 1'b1;
    step(); halt_req = 1'b0;
    chk("halt3", {31'b0, halted}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_halted", {31'b0, halted}, 32'h0);
    chk("mid_rst_epc", epc, 32'h0);
    #3 rst = 1'b0;
    step(); chk("reboot_valid", {31'b0, pc_valid}, 32'h1);
    step(); chk("reboot_pc", pc, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
